noc_ni_tx: RTL

- Processor-to-NoC transmit network interface. It is the responder on the processor send interface (proc_valid / proc_ready / destination / 32-bit payload) driven from the MIPS EX stage.
- It buffers send requests in a small FIFO and packetizes each into a two-flit packet (HEAD, TAIL). Flits go to the local router port over a valid/ready link.
- It backpressures the processor through proc_ready when the buffer is full.

---
 rtl/noc_pkg.sv | 33 +++
 rtl/noc_sync_fifo.sv | 65 ++++++
 rtl/noc_ni_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit type codes, NI transmit FSM encoding
// and the head/tail flit builders.
package noc_pkg;

    localparam int unsigned FLIT_W        = 34;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned TYPE_LSB      = 32;
    localparam int unsigned ID_W          = 2;
    localparam int unsigned HEAD_DEST_LSB = 0;
    localparam int unsigned HEAD_SRC_LSB  = 2;

    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b01;

    localparam logic [1:0] NI_IDLE = 2'd0;
    localparam logic [1:0] NI_HEAD = 2'd1;
    localparam logic [1:0] NI_TAIL = 2'd2;

    function automatic logic [FLIT_W-1:0] make_head(input logic [ID_W-1:0] src,
                                                    input logic [ID_W-1:0] dest);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[TYPE_LSB +: 2]          = FT_HEAD;
        f[HEAD_SRC_LSB +: ID_W]   = src;
        f[HEAD_DEST_LSB +: ID_W]  = dest;
        return f;
    endfunction

    function automatic logic [FLIT_W-1:0] make_tail(input logic [DATA_W-1:0] data);
        return {FT_TAIL, data};
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with occupancy count; the read port can peek one entry past the head.
// Storage is not reset, only pointers and count.
module noc_sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic                       rd_next,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AW-1:0]    peek_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_en && !empty;
    assign peek_ptr = rd_ptr_q + AW'(rd_next);
    assign rd_data  = mem_q[peek_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_wr && !do_rd) count_d = count_q + CNT_W'(1);
        else if (!do_wr && do_rd) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/noc_ni_tx.sv
// Processor-to-NoC transmit NI: buffers send requests and emits each as a
// registered HEAD/TAIL flit pair toward the local router port.
module noc_ni_tx
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NODE_ID = 0,
    parameter int unsigned DEST_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    proc_valid,
    input  logic [DEST_W-1:0]       proc_dest,
    input  logic [31:0]             proc_data,
    output logic                    proc_ready,
    output logic [33:0]             flit_out,
    output logic                    flit_valid,
    input  logic                    flit_ready,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    busy
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = DEST_W + DATA_W;

    logic [1:0]        state_q, state_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              flit_valid_q, flit_valid_d;

    logic               push;
    logic               pop;
    logic               rd_next;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DEST_W-1:0]  rd_dest;
    logic [DATA_W-1:0]  rd_data;
    logic [FLIT_W-1:0]  head_flit;
    logic [FLIT_W-1:0]  tail_flit;

    assign proc_ready = !fifo_full;
    assign push       = proc_valid && !fifo_full;
    // In TAIL the next HEAD comes from the entry behind the one being retired.
    assign rd_next    = (state_q == NI_TAIL);
    assign rd_dest    = fifo_rd_data[DATA_W +: DEST_W];
    assign rd_data    = fifo_rd_data[DATA_W-1:0];
    assign head_flit  = make_head(ID_W'(NODE_ID), ID_W'(rd_dest));
    assign tail_flit  = make_tail(rd_data);

    noc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({proc_dest, proc_data}),
        .rd_en   (pop),
        .rd_next (rd_next),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        flit_d       = flit_q;
        flit_valid_d = flit_valid_q;
        pop          = 1'b0;
        case (state_q)
            NI_IDLE: begin
                if (!fifo_empty) begin
                    flit_d       = head_flit;
                    flit_valid_d = 1'b1;
                    state_d      = NI_HEAD;
                end else begin
                    flit_valid_d = 1'b0;
                end
            end
            NI_HEAD: begin
                if (flit_ready) begin
                    flit_d  = tail_flit;
                    state_d = NI_TAIL;
                end
            end
            NI_TAIL: begin
                if (flit_ready) begin
                    pop = 1'b1;
                    // Decision uses the pre-pop count; a concurrent push is not visible here.
                    if (fifo_count > CNT_W'(1)) begin
                        flit_d  = head_flit;
                        state_d = NI_HEAD;
                    end else begin
                        flit_valid_d = 1'b0;
                        state_d      = NI_IDLE;
                    end
                end
            end
            default: begin
                flit_valid_d = 1'b0;
                state_d      = NI_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= NI_IDLE;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
        end
    end

    assign flit_out   = flit_q;
    assign flit_valid = flit_valid_q;
    assign pending    = fifo_count;
    assign busy       = (state_q != NI_IDLE) || (fifo_count != '0);

endmodule
